bsg_kda_client_responder: RTL and testbench
===========================================

Name: bsg_kda_client_responder

Overview:
- Client-side (ASIC-end) responder for master test traffic on one ring channel.
- Accepts request packets from the channel's incoming valid/ready stream and returns response packets on the outgoing valid/yumi stream.
- Counts completed transactions and raises a sticky done flag; the master side's done detection relies on it.

Parameters:
- width_p, 80, ring word width in bits (10 ring bytes); must be >= 16.
- max_len_p, 16, payload buffer depth in words; payload lengths 0..max_len_p are legal.
- iterations_p, 16, number of completed responses after which done_o asserts.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  request word valid.
- data_i  in  width_p  request word.
- ready_o  out  1  responder can accept a request word this cycle.
- v_o  out  1  response word valid.
- data_o  out  width_p  response word.
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1.
- done_o  out  1  sticky; iterations_p responses completed.
- err_o  out  1  sticky; an oversize or reserved request was seen.

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous, active-high.
- Header word format:
  - data_i[width_p-1:width_p-2] = opcode: 00 ECHO, 01 SUM, 10 COUNT, 11 reserved.
  - data_i[7:0] = payload length L.
  - Remaining bits ignored.
- Reset: state=IDLE; ready_o=1, v_o=0, data_o=0, done_o=0, err_o=0; word counter, sum accumulator, response counter and buffer pointers cleared.
- Input transfer on v_i & ready_o. Output transfer on yumi_i; yumi_i while v_o=0 is a protocol violation (assertion).
- FSM states: IDLE, COLLECT, DRAIN, RESPOND.
- IDLE (ready_o=1): header accept latches opcode and L.
  - L > max_len_p or opcode 11: set err_o, go to DRAIN.
  - L = 0: go to RESPOND for SUM/COUNT; stay in IDLE for ECHO.
  - Otherwise go to COLLECT.
- COLLECT (ready_o=1):
  - Each accepted word: ECHO writes it to the buffer; SUM adds it to the accumulator mod 2^width_p.
  - After the L-th word, go to RESPOND.
- DRAIN (ready_o=1): discard L words, then return to IDLE. No response; response counter unchanged.
- RESPOND (ready_o=0, v_o=1):
  - ECHO: emits L words in arrival order.
  - SUM: emits one word = sum of payload (0 when L=0).
  - COUNT: emits one word = zero-extended value of the response counter before increment.
  - Advance on yumi_i. After the last word is taken: IDLE, response counter +1.
- Latency: v_o rises the cycle after the last payload word (or header if L=0) is accepted. data_o holds stable while v_o=1 and yumi_i=0. Back-to-back yumi_i yields one word per cycle.
- Response counter is 16 bits and saturates at 0xFFFF.
- done_o sets in the cycle the counter reaches iterations_p; it is sticky until reset.
- No input is accepted during RESPOND; upstream backpressure only.
- reset_i asserted mid-packet: all state returns to reset values next cycle; partial buffer contents are discarded; no response is emitted.

Optional Feature:
- Macro: KDA_CLIENT_TRAILER_EN.
- Defined: every response gets one extra trailer word after the normal words.
  - Trailer bits [15:0] = response counter before increment; bit [width_p-1] = 1; other bits 0.
  - Counter increments only after the trailer is taken.
  - ECHO with L=0 also emits the trailer alone (goes to RESPOND).
- Undefined: no trailer; behaviour exactly as above.

Test Plan:
- ECHO L=3, payload 0xA,0xB,0xC, yumi_i held 1 -> v_o rises the cycle after 0xC is accepted; data_o = 0xA,0xB,0xC on consecutive cycles; ready_o=0 throughout RESPOND.
- SUM L=4, payload 1,2,3,(2^width_p-1) -> single word 5 (mod wrap); response counter = 1.
- ECHO with random yumi_i stalls -> data_o stable during stalls; order preserved; no duplicated or lost words.
- Header L=max_len_p+1 -> err_o=1; the L following words are absorbed with no v_o; next COUNT request returns 0.
- 16 SUM requests with L=1 -> done_o rises exactly after the 16th response is taken; a 17th request is still served; done_o stays 1.
- reset_i pulsed after 2 of 5 ECHO payload words -> next cycle v_o=0, ready_o=1; fresh ECHO L=1 0x55 returns 0x55 only.

Source files
------------

// File: rtl/bsg_kda_client_responder.sv
// bsg_kda_client_responder
// Client-side responder for ring-channel master test traffic. Accepts
// ECHO / SUM / COUNT request packets on a valid/ready stream and returns
// response packets on a valid/yumi stream. Counts completed responses and
// raises a sticky done flag; flags oversize or reserved requests as err.
// Optional feature: define KDA_CLIENT_TRAILER_EN to append one trailer word
// (bit [width_p-1] set, low 16 bits = response count) to every response.
module bsg_kda_client_responder #(
  parameter int width_p      = 80,
  parameter int max_len_p    = 16,
  parameter int iterations_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, RESPOND} state_e;

  localparam logic [1:0] OpEcho  = 2'b00;
  localparam logic [1:0] OpSum   = 2'b01;
  localparam logic [1:0] OpCount = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;
  localparam int         AW      = (max_len_p > 1) ? $clog2(max_len_p) : 1;
  localparam logic [7:0] MaxLen  = 8'(max_len_p);
  localparam logic [15:0] IterCount = 16'(iterations_p);
`ifdef KDA_CLIENT_TRAILER_EN
  localparam logic [7:0] TrailerWords = 8'd1;
`else
  localparam logic [7:0] TrailerWords = 8'd0;
`endif

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         rd_q, rd_d;
  logic [width_p-1:0] sum_q, sum_d;
  logic [15:0]        resp_q, resp_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [width_p-1:0] buf_q [max_len_p];
  logic               buf_we;

  logic               in_xfer;
  logic [1:0]         hdr_op;
  logic [7:0]         hdr_len;
  logic [7:0]         normal_words;
  logic [7:0]         last_idx;
  logic [15:0]        resp_inc;

  assign in_xfer      = v_i & ready_o;
  assign hdr_op       = data_i[width_p-1 -: 2];
  assign hdr_len      = data_i[7:0];
  assign normal_words = (op_q == OpEcho) ? len_q : 8'd1;
  assign last_idx     = normal_words + TrailerWords - 8'd1;
  assign resp_inc     = (resp_q == 16'hFFFF) ? resp_q : resp_q + 16'd1;

  assign ready_o = (state_q != RESPOND);
  assign v_o     = (state_q == RESPOND);
  assign done_o  = done_q;
  assign err_o   = err_q;

  // Select the response word currently presented; zero outside RESPOND
  always_comb begin
    data_o = '0;
    if (state_q == RESPOND) begin
      if ((TrailerWords != 8'd0) && (rd_q == normal_words)) begin
        data_o = {1'b1, {(width_p-17){1'b0}}, resp_q};
      end else begin
        case (op_q)
          OpSum:   data_o = sum_q;
          OpCount: data_o = {{(width_p-16){1'b0}}, resp_q};
          default: data_o = buf_q[rd_q[AW-1:0]];
        endcase
      end
    end
  end

  // Next-state logic: packet parsing, payload collection, draining and response sequencing
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    sum_d   = sum_q;
    resp_d  = resp_q;
    done_d  = done_q;
    err_d   = err_q;
    buf_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          op_d  = hdr_op;
          len_d = hdr_len;
          cnt_d = '0;
          rd_d  = '0;
          sum_d = '0;
          if ((hdr_op == OpRsvd) || (hdr_len > MaxLen)) begin
            err_d   = 1'b1;
            state_d = (hdr_len == 8'd0) ? IDLE : DRAIN;
          end else if (hdr_len == 8'd0) begin
            state_d = ((hdr_op != OpEcho) || (TrailerWords != 8'd0)) ? RESPOND : IDLE;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (in_xfer) begin
          buf_we = (op_q == OpEcho);
          if (op_q == OpSum) sum_d = sum_q + data_i;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = RESPOND;
        end
      end
      DRAIN: begin
        if (in_xfer) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = IDLE;
        end
      end
      RESPOND: begin
        if (yumi_i) begin
          rd_d = rd_q + 8'd1;
          if (rd_q == last_idx) begin
            state_d = IDLE;
            resp_d  = resp_inc;
            if (resp_inc == IterCount) done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      resp_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      resp_q  <= resp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ECHO payload buffer; contents are don't-care until written by the current packet
  always_ff @(posedge clk_i) begin
    if (!reset_i && buf_we) buf_q[cnt_q[AW-1:0]] <= data_i;
  end

  // Consumer must only take a word that is being offered
  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_kda_client_responder.sv
// Testbench for bsg_kda_client_responder (default build, trailer disabled).
// Table-driven vectors for the basic opcodes plus hand-written sequences for
// stalls, mid-packet reset, oversize drain and the done threshold.
module tb_bsg_kda_client_responder;

  localparam int W = 80;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i;
  logic         done_o;
  logic         err_o;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] data;
    logic         yumi;
    logic         expReady;
    logic         expV;
    logic [W-1:0] expData;
    logic         expDone;
    logic         expErr;
  } vec_t;

  vec_t vecs[$];

  bsg_kda_client_responder #(.width_p(W), .max_len_p(16), .iterations_p(16)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] hdr(input logic [1:0] op, input logic [7:0] len);
    logic [W-1:0] h;
    h = '0;
    h[W-1 -: 2] = op;
    h[7:0] = len;
    return h;
  endfunction

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic y,
                              input logic er, input logic ev, input logic [W-1:0] ed,
                              input logic edn, input logic eer);
    vec_t r;
    r.v = v; r.data = d; r.yumi = y;
    r.expReady = er; r.expV = ev; r.expData = ed; r.expDone = edn; r.expErr = eer;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic y);
    v_i = v;
    data_i = d;
    yumi_i = y;
    @(negedge clk_i);
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    v_i = 1'b0;
    yumi_i = 1'b0;
    data_i = '0;
    advance();
    reset_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("resetState", {ready_o, v_o, data_o, done_o, err_o},
                {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0});
    advance();
  endtask

  logic [W-1:0] allOnes;
  logic [W-1:0] echoData [16];
  int idx;
  int cycles;
  logic y;

  // Main directed test sequence
  initial begin
    allOnes = '1;
    doReset();

    // ECHO L=3
    vecs.push_back(mk(1, hdr(2'b00, 8'd3), 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'hA, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'hB, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'hC, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(0, '0, 1, 0, 1, 80'hA, 0, 0));
    vecs.push_back(mk(0, '0, 1, 0, 1, 80'hB, 0, 0));
    vecs.push_back(mk(0, '0, 1, 0, 1, 80'hC, 0, 0));
    // SUM L=4 with wraparound
    vecs.push_back(mk(1, hdr(2'b01, 8'd4), 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'd1, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'd2, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'd3, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, allOnes, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(0, '0, 1, 0, 1, 80'd5, 0, 0));
    // ECHO L=0 produces nothing
    vecs.push_back(mk(1, hdr(2'b00, 8'd0), 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(0, '0, 0, 1, 0, '0, 0, 0));
    // COUNT L=0 with one stall cycle; two responses completed so far
    vecs.push_back(mk(1, hdr(2'b10, 8'd0), 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(0, '0, 0, 0, 1, 80'd2, 0, 0));
    vecs.push_back(mk(0, '0, 1, 0, 1, 80'd2, 0, 0));
    // Reserved opcode L=2 sets err and drains two words
    vecs.push_back(mk(1, hdr(2'b11, 8'd2), 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(1, 80'h77, 0, 1, 0, '0, 0, 1));
    vecs.push_back(mk(1, 80'h88, 0, 1, 0, '0, 0, 1));
    // COUNT afterwards is unaffected by the drained packet
    vecs.push_back(mk(1, hdr(2'b10, 8'd0), 0, 1, 0, '0, 0, 1));
    vecs.push_back(mk(0, '0, 1, 0, 1, 80'd3, 0, 1));
    vecs.push_back(mk(0, '0, 0, 1, 0, '0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].data, vecs[i].yumi);
      checkOutput($sformatf("vec%0d", i), {ready_o, v_o, data_o, done_o, err_o},
                  {vecs[i].expReady, vecs[i].expV, vecs[i].expData, vecs[i].expDone, vecs[i].expErr});
      advance();
    end

    // ECHO L=max_len_p with random consumer stalls
    for (int i = 0; i < 16; i++) echoData[i] = {16'(i), $urandom(), $urandom()};
    applyStimulus(1'b1, hdr(2'b00, 8'd16), 1'b0);
    advance();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, echoData[i], 1'b0);
      advance();
    end
    idx = 0;
    cycles = 0;
    while (idx < 16 && cycles < 200) begin
      y = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, '0, y);
      checkOutput($sformatf("echoStall%0d", idx), {2'b00, ready_o, v_o, data_o},
                  {2'b00, 1'b0, 1'b1, echoData[idx]});
      if (y) idx++;
      advance();
      cycles++;
    end
    checkOutput("echoStallCount", (W+4)'(idx), (W+4)'(16));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("echoStallEnd", {ready_o, v_o, data_o, 2'b00}, {1'b1, 1'b0, {W{1'b0}}, 2'b00});
    advance();

    // Reset after 2 of 5 ECHO payload words
    applyStimulus(1'b1, hdr(2'b00, 8'd5), 1'b0);
    advance();
    applyStimulus(1'b1, 80'h11, 1'b0);
    advance();
    applyStimulus(1'b1, 80'h22, 1'b0);
    advance();
    reset_i = 1'b1;
    v_i = 1'b0;
    advance();
    reset_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midResetOut", {ready_o, v_o, data_o, done_o, err_o},
                {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0});
    advance();
    applyStimulus(1'b1, hdr(2'b00, 8'd1), 1'b0);
    advance();
    applyStimulus(1'b1, 80'h55, 1'b0);
    advance();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("midResetEcho", {ready_o, v_o, data_o, 2'b00}, {1'b0, 1'b1, 80'h55, 2'b00});
    advance();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midResetEchoEnd", {ready_o, v_o, data_o, 2'b00}, {1'b1, 1'b0, {W{1'b0}}, 2'b00});
    advance();

    // Oversize header: err, absorb 17 words with no response, then COUNT returns 0
    doReset();
    applyStimulus(1'b1, hdr(2'b00, 8'd17), 1'b0);
    advance();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 80'(i + 100), 1'b0);
      checkOutput($sformatf("drain%0d", i), (W+4)'({ready_o, v_o, err_o}), (W+4)'(3'b101));
      advance();
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("drainEnd", (W+4)'({ready_o, v_o, err_o}), (W+4)'(3'b101));
    advance();
    applyStimulus(1'b1, hdr(2'b10, 8'd0), 1'b0);
    advance();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("countAfterDrain", {v_o, data_o, 3'b000}, {1'b1, {W{1'b0}}, 3'b000});
    advance();

    // Done threshold: 16 SUM L=1 requests, then a 17th
    doReset();
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b1, hdr(2'b01, 8'd1), 1'b0);
      checkOutput($sformatf("doneHdr%0d", k), (W+4)'(done_o), (W+4)'(k > 16));
      advance();
      applyStimulus(1'b1, 80'(k), 1'b0);
      advance();
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("doneResp%0d", k), {v_o, data_o, done_o, 2'b00},
                  {1'b1, 80'(k), 1'(k > 16), 2'b00});
      advance();
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("doneSticky", (W+4)'({done_o, ready_o, v_o}), (W+4)'(3'b110));
    advance();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
